// File: rtl/div_arbiter_if.sv
// div_arbiter_if: requester and divider handshake bundle shared by div_arbiter and its users
interface div_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
);
    logic [N_REQ-1:0]            i_req;
    logic [N_REQ-1:0][WIDTH-1:0] i_num;
    logic [N_REQ-1:0][WIDTH-1:0] i_denom;
    logic [N_REQ-1:0]            o_ack;
    logic [WIDTH-1:0]            o_result;
    logic                        o_err;
    logic                        o_busy;
    logic [WIDTH-1:0]            o_div_num;
    logic [WIDTH-1:0]            o_div_denom;
    logic                        o_div_start;
    logic [WIDTH-1:0]            i_div_result;
    logic                        i_div_done;
    logic                        i_div_valid;

    modport slave (
        input  i_req, i_num, i_denom, i_div_result, i_div_done, i_div_valid,
        output o_ack, o_result, o_err, o_busy, o_div_num, o_div_denom, o_div_start
    );

    modport master (
        output i_req, i_num, i_denom, i_div_result, i_div_done, i_div_valid,
        input  o_ack, o_result, o_err, o_busy, o_div_num, o_div_denom, o_div_start
    );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter sharing one divider among N_REQ requesters
module div_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 16,
    parameter int QBITS   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    div_arbiter_if.slave bus
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    // QBITS describes the fixed-point format of the operands; it only travels with the data here
    if (QBITS > WIDTH) begin : g_qbits_wider_than_data
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    grant_q, grant_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [WIDTH-1:0] denom_q, denom_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             err_q, err_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    sel;
    logic [PW-1:0]    idx;

    // Round-robin pick: the first requesting index after ptr, wrapping; descending scan lets the nearest win
    always_comb begin
        sel = ptr_q;
        idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = PW'((int'(ptr_q) + k) % N_REQ);
            if (bus.i_req[idx]) sel = idx;
        end
    end

    // Next-state logic; the WAIT counter is 0 only in the first WAIT cycle, which masks a stale done
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        num_d   = num_q;
        denom_d = denom_q;
        res_d   = res_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|bus.i_req) begin
                    grant_d = sel;
                    num_d   = bus.i_num[sel];
                    denom_d = bus.i_denom[sel];
                    cnt_d   = '0;
                    state_d = (bus.i_denom[sel] == '0) ? RESP : ISSUE;
                    res_d   = (bus.i_denom[sel] == '0) ? '1 : '0;
                    err_d   = (bus.i_denom[sel] == '0);
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.i_div_done && cnt_q != '0) begin
                    res_d   = bus.i_div_result;
                    err_d   = ~bus.i_div_valid;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                ptr_d   = grant_q;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; ptr resets so index 0 wins first
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PW'(N_REQ - 1);
            grant_q <= '0;
            num_q   <= '0;
            denom_q <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            num_q   <= num_d;
            denom_q <= denom_d;
            res_q   <= res_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are decoded from state so they read zero whenever their qualifying state is absent
    always_comb begin
        bus.o_busy      = state_q != IDLE;
        bus.o_div_start = state_q == ISSUE;
        bus.o_div_num   = (state_q == ISSUE || state_q == WAIT) ? num_q : '0;
        bus.o_div_denom = (state_q == ISSUE || state_q == WAIT) ? denom_q : '0;
        bus.o_ack       = (state_q == RESP) ? (N_REQ)'(1) << grant_q : '0;
        bus.o_result    = (state_q == RESP) ? res_q : '0;
        bus.o_err       = (state_q == RESP) && err_q;
    end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed self-checking bench for div_arbiter
module tb_div_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;
    int   starts = 0;
    int   s0;

    div_arbiter_if #(.N_REQ(4), .WIDTH(16)) bus ();

    div_arbiter #(.N_REQ(4), .WIDTH(16), .QBITS(8), .TIMEOUT(255)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Count divider start pulses seen at rising edges
    always @(posedge clk) if (bus.o_div_start) starts <= starts + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_req = '0;
        bus.i_div_done = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One divider transaction starting from an IDLE cycle with the request already driven.
    // lat counts WAIT cycles including the done cycle; stress drops the request and pulses a stale done.
    task automatic txn(input int idx, input logic [15:0] num, input logic [15:0] den, input int lat,
                       input logic [15:0] res, input logic valid, input logic exp_err, input logic stress);
        int b;
        b = starts;
        tick();
        chk("issue_start", bus.o_div_start, 1);
        chk("issue_num", bus.o_div_num, num);
        chk("issue_denom", bus.o_div_denom, den);
        if (stress) bus.i_req = '0;
        tick();
        chk("wait_start_low", bus.o_div_start, 0);
        chk("wait_num_held", bus.o_div_num, num);
        if (stress) begin
            bus.i_div_done = 1'b1;
            bus.i_div_result = 16'hDEAD;
            bus.i_div_valid = 1'b1;
            tick();
            bus.i_div_done = 1'b0;
            chk("first_wait_done_ignored", bus.o_ack, 0);
            chk("still_busy", bus.o_busy, 1);
            repeat (lat - 2) tick();
        end else begin
            repeat (lat - 1) tick();
        end
        bus.i_div_done = 1'b1;
        bus.i_div_result = res;
        bus.i_div_valid = valid;
        chk("no_ack_on_done_cycle", bus.o_ack, 0);
        chk("no_result_without_ack", bus.o_result, 0);
        tick();
        bus.i_div_done = 1'b0;
        chk("ack", bus.o_ack, 32'(4'b0001 << idx));
        chk("result", bus.o_result, res);
        chk("err", bus.o_err, exp_err);
        chk("one_start", starts - b, 1);
        tick();
        chk("idle_busy", bus.o_busy, 0);
        chk("idle_ack", bus.o_ack, 0);
        chk("idle_result", bus.o_result, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_req = '0;
        bus.i_num = '0;
        bus.i_denom = '0;
        bus.i_div_result = '0;
        bus.i_div_done = 1'b0;
        bus.i_div_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_ack", bus.o_ack, 0);
        chk("rst_result", bus.o_result, 0);
        chk("rst_err", bus.o_err, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_start", bus.o_div_start, 0);
        chk("rst_div_num", bus.o_div_num, 0);
        chk("rst_div_denom", bus.o_div_denom, 0);

        // Single request 0x0600 / 0x0200, done 10 cycles after start, request dropped while granted
        bus.i_num[0] = 16'h0600;
        bus.i_denom[0] = 16'h0200;
        bus.i_req = 4'b0001;
        txn(0, 16'h0600, 16'h0200, 10, 16'h0300, 1'b1, 1'b0, 1'b1);

        // Fairness from reset with all four requesting continuously
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.i_num[i] = 16'(16'h0100 * (i + 1));
            bus.i_denom[i] = 16'h0001;
        end
        bus.i_req = 4'b1111;
        txn(0, 16'h0100, 16'h0001, 4, 16'h0100, 1'b1, 1'b0, 1'b0);
        txn(1, 16'h0200, 16'h0001, 3, 16'h0200, 1'b1, 1'b0, 1'b0);
        txn(2, 16'h0300, 16'h0001, 2, 16'h0300, 1'b1, 1'b0, 1'b0);
        txn(3, 16'h0400, 16'h0001, 5, 16'h0400, 1'b1, 1'b0, 1'b0);
        txn(0, 16'h0100, 16'h0001, 2, 16'h0100, 1'b1, 1'b0, 1'b0);
        bus.i_req = '0;

        // Divide by zero on requester 2: ack the next cycle without starting the divider
        bus.i_denom[2] = 16'h0000;
        bus.i_req = 4'b0100;
        s0 = starts;
        tick();
        bus.i_req = '0;
        chk("dz_ack", bus.o_ack, 32'h4);
        chk("dz_result", bus.o_result, 32'hFFFF);
        chk("dz_err", bus.o_err, 1);
        chk("dz_no_start", bus.o_div_start, 0);
        tick();
        chk("dz_idle_ack", bus.o_ack, 0);
        chk("dz_start_count", starts - s0, 0);

        // Invalid divider result on requester 1 (ptr now 2, scan 3,0,1)
        bus.i_req = 4'b0010;
        txn(1, 16'h0200, 16'h0001, 3, 16'h1234, 1'b0, 1'b1, 1'b0);
        bus.i_req = '0;

        // Timeout on requester 3: divider never finishes, 255 WAIT cycles then error ack
        bus.i_div_result = 16'hBEEF;
        bus.i_div_valid = 1'b1;
        bus.i_req = 4'b1000;
        tick();
        chk("to_start", bus.o_div_start, 1);
        bus.i_req = '0;
        tick();
        repeat (254) tick();
        chk("to_no_early_ack", bus.o_ack, 0);
        chk("to_busy_last_wait", bus.o_busy, 1);
        tick();
        chk("to_ack", bus.o_ack, 32'h8);
        chk("to_result", bus.o_result, 0);
        chk("to_err", bus.o_err, 1);
        tick();
        chk("to_idle", bus.o_busy, 0);
        bus.i_req = 4'b0001;
        txn(0, 16'h0100, 16'h0001, 5, 16'h0042, 1'b1, 1'b0, 1'b0);
        bus.i_req = '0;

        // Reset in the middle of WAIT for requester 1, then a late done
        bus.i_req = 4'b0010;
        tick();
        tick();
        tick();
        chk("mid_busy", bus.o_busy, 1);
        bus.i_req = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_ack", bus.o_ack, 0);
        chk("mr_busy", bus.o_busy, 0);
        chk("mr_start", bus.o_div_start, 0);
        chk("mr_div_num", bus.o_div_num, 0);
        chk("mr_div_denom", bus.o_div_denom, 0);
        chk("mr_result", bus.o_result, 0);
        chk("mr_err", bus.o_err, 0);
        bus.i_div_done = 1'b1;
        bus.i_div_result = 16'h7777;
        tick();
        bus.i_div_done = 1'b0;
        chk("late_done_busy", bus.o_busy, 0);
        chk("late_done_ack", bus.o_ack, 0);
        bus.i_req = 4'b0011;
        txn(0, 16'h0100, 16'h0001, 3, 16'h0055, 1'b1, 1'b0, 1'b0);
        bus.i_req = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
